// File: rtl/sopc_2_pio_pkg.sv
// Shared definitions for the SOPC PIO peripherals.
// Holds the register map and the default blink half-period.
package sopc_2_pio_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
    localparam logic [2:0] ADDR_PERIOD   = 3'd2;
    localparam logic [2:0] ADDR_STATUS   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    // 0.5 s half-period at 50 MHz.
    localparam logic [31:0] DEFAULT_PERIOD_RESET = 32'd24999999;

endpackage

// File: rtl/sopc_2_blink_timer.sv
// Free-running half-period counter for the LED PIO.
// Produces a phase bit that flips every (period + 1) clocks.
module sopc_2_blink_timer
    import sopc_2_pio_pkg::*;
#(
    parameter logic [31:0] PERIOD_RESET = DEFAULT_PERIOD_RESET
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_load,
    input  logic [31:0] i_load_value,
    output logic [31:0] o_period,
    output logic        o_phase
);

    logic [31:0] r_period;
    logic [31:0] r_cnt;
    logic        r_phase;

    // A period load restarts the count and phase, and outranks the terminal-count toggle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_period <= PERIOD_RESET;
            r_cnt    <= '0;
            r_phase  <= 1'b0;
        end else if (i_load) begin
            r_period <= i_load_value;
            r_cnt    <= '0;
            r_phase  <= 1'b0;
        end else if (r_cnt == r_period) begin
            r_cnt    <= '0;
            r_phase  <= ~r_phase;
        end else begin
            r_cnt    <= r_cnt + 32'd1;
        end
    end

    assign o_period = r_period;
    assign o_phase  = r_phase;

endmodule

// File: rtl/sopc_2_led_pio.sv
// Avalon-MM output PIO driving the board LEDs, with set/clear and per-bit blink.
// Read data and LED drive are both registered.
module sopc_2_led_pio
    import sopc_2_pio_pkg::*;
#(
    parameter int unsigned       WIDTH        = 10,
    parameter logic [WIDTH-1:0]  RESET_VALUE  = '0,
    parameter logic [31:0]       PERIOD_RESET = DEFAULT_PERIOD_RESET
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [WIDTH-1:0]  out_port
);

    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_blink_en;
    logic [31:0]      r_readdata;
    logic [WIDTH-1:0] r_out;

    logic             w_wr;
    logic             w_load;
    logic [31:0]      w_period;
    logic             w_phase;
    logic [31:0]      w_rd_mux;
    logic [WIDTH-1:0] w_out_next;

    assign w_wr   = chipselect & ~write_n;
    assign w_load = w_wr && (address == ADDR_PERIOD);

    sopc_2_blink_timer #(
        .PERIOD_RESET (PERIOD_RESET)
    ) u_blink_timer (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_load       (w_load),
        .i_load_value (writedata),
        .o_period     (w_period),
        .o_phase      (w_phase)
    );

    always_comb begin
        w_rd_mux = '0;
        case (address)
            ADDR_DATA:     w_rd_mux[WIDTH-1:0] = r_data;
            ADDR_BLINK_EN: w_rd_mux[WIDTH-1:0] = r_blink_en;
            ADDR_PERIOD:   w_rd_mux            = w_period;
            ADDR_STATUS:   w_rd_mux[0]         = w_phase;
            default:       w_rd_mux            = '0;
        endcase
    end

    // Blinking bits go dark while phase is 1; others follow data.
    generate
        for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_out_bit
            assign w_out_next[gi] = r_data[gi] & ~(r_blink_en[gi] & w_phase);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data     <= RESET_VALUE;
            r_blink_en <= '0;
            r_readdata <= '0;
            r_out      <= RESET_VALUE;
        end else begin
            r_readdata <= w_rd_mux;
            r_out      <= w_out_next;
            if (w_wr) begin
                case (address)
                    ADDR_DATA:     r_data     <= writedata[WIDTH-1:0];
                    ADDR_BLINK_EN: r_blink_en <= writedata[WIDTH-1:0];
                    ADDR_OUTSET:   r_data     <= r_data | writedata[WIDTH-1:0];
                    ADDR_OUTCLEAR: r_data     <= r_data & ~writedata[WIDTH-1:0];
                    default:       ;
                endcase
            end
        end
    end

    assign readdata = r_readdata;
    assign out_port = r_out;

endmodule

// File: tb/tb_sopc_2_led_pio.sv
// Scoreboard bench for sopc_2_led_pio: stimulus queues expectations keyed by
// clock edge, a negedge monitor pops and compares them.
module tb_sopc_2_led_pio;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [9:0]  out_port;

    typedef struct {
        int          cyc;
        bit          is_rd;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    sopc_2_led_pio dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=0x%08h expected=0x%08h", name, cyc, act, exp);
        end else begin
            $display("ok   %s cyc=%0d value=0x%08h", name, cyc, act);
        end
    endtask

    task automatic expect_at(input int c, input bit is_rd, input logic [31:0] e, input string name);
        exp_t x;
        x.cyc = c; x.is_rd = is_rd; x.exp = e; x.name = name;
        q.push_back(x);
    endtask

    // Monitor: compare every expectation due at this edge.
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc < cyc) begin
                errors++;
                checks++;
                $display("FAIL %s stale expectation for cyc=%0d now=%0d", q[i].name, q[i].cyc, cyc);
                q.delete(i);
            end else if (q[i].cyc == cyc) begin
                if (q[i].is_rd) chk(q[i].name, readdata, q[i].exp);
                else            chk(q[i].name, 32'(out_port), q[i].exp);
                q.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e, input string name);
        address = a;
        tick();
        expect_at(cyc, 1'b1, e, name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int p;
        int qe;
        int ph;
        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = '0;
        #1;
        chk("rst_out_hold", 32'(out_port), 32'h0);
        chk("rst_rd_hold", readdata, 32'h0);
        repeat (3) tick();
        reset_n = 1'b1;
        expect_at(cyc + 1, 1'b0, 32'h0, "rel_out");
        expect_at(cyc + 1, 1'b1, 32'h0, "rel_rd");
        tick();
        rd(3'd2, 32'h017D783F, "rd_period_reset");

        // Full data write, pre-write read, then post-write read.
        address = 3'd0;
        wr(3'd0, 32'h3FF);
        expect_at(cyc, 1'b0, 32'h0, "data_out_before");
        expect_at(cyc, 1'b1, 32'h0, "data_rd_prewrite");
        expect_at(cyc + 1, 1'b0, 32'h3FF, "data_out_after");
        rd(3'd0, 32'h3FF, "rd_data_3ff");

        // Set / clear.
        wr(3'd0, 32'h00F);
        wr(3'd4, 32'h300);
        expect_at(cyc + 1, 1'b0, 32'h30F, "outset_out");
        wr(3'd5, 32'h003);
        expect_at(cyc + 1, 1'b0, 32'h30C, "outclear_out");
        rd(3'd0, 32'h30C, "rd_data_30c");

        // Blink with period 3: phase flips every 4 clocks.
        wr(3'd2, 32'd3);
        p = cyc;
        wr(3'd1, 32'h00C);
        wr(3'd0, 32'h00F);
        address = 3'd3;
        for (int e = p + 3; e <= p + 18; e++) begin
            ph = ((e - 1 - p) / 4) % 2;
            expect_at(e, 1'b0, (ph != 0) ? 32'h003 : 32'h00F, "blink_out");
            expect_at(e, 1'b1, 32'(ph), "blink_status");
        end
        while (cyc < p + 18) tick();

        // Period 0 written while cnt is mid-count: restart, then toggle each clock.
        address = 3'd2;
        wr(3'd2, 32'd0);
        qe = cyc;
        expect_at(qe, 1'b1, 32'd3, "period_rd_prewrite");
        address = 3'd3;
        for (int e = qe + 1; e <= qe + 8; e++) begin
            ph = (e - 1 - qe) % 2;
            expect_at(e, 1'b1, 32'(ph), "p0_status");
            expect_at(e, 1'b0, (ph != 0) ? 32'h003 : 32'h00F, "p0_out");
        end
        while (cyc < qe + 8) tick();

        // Writes to read-only / unused addresses change nothing.
        wr(3'd3, 32'hFFFF_FFFF);
        wr(3'd6, 32'hFFFF_FFFF);
        wr(3'd7, 32'hFFFF_FFFF);
        rd(3'd0, 32'h00F, "ro_data");
        rd(3'd1, 32'h00C, "ro_blink_en");
        rd(3'd2, 32'h0, "ro_period");
        rd(3'd4, 32'h0, "rd_addr4_zero");
        rd(3'd6, 32'h0, "rd_addr6_zero");

        // Asynchronous reset mid-blink.
        wr(3'd0, 32'h155);
        tick();
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_rst_out", 32'(out_port), 32'h0);
        chk("async_rst_rd", readdata, 32'h0);
        repeat (2) tick();
        reset_n = 1'b1;
        address = 3'd0;
        expect_at(cyc + 1, 1'b0, 32'h0, "post_rst_out");
        tick();
        rd(3'd1, 32'h0, "post_rst_blink_en");
        rd(3'd2, 32'h017D783F, "post_rst_period");
        rd(3'd0, 32'h0, "post_rst_data");

        repeat (3) tick();
        if (q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_drain left=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
